// File: rtl/i2s_rx.sv
// I2S / left-justified ADC receiver. Generates bck and lrck from clk, captures
// din in the clk domain, and queues complete {left, right} pairs in a small FIFO.
module i2s_rx #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BCK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                en,
    input  logic                fmt,
    input  logic                din,
    output logic                bck,
    output logic                lrck,
    output logic                scki,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    input  logic                clear_ovf
);

    localparam int FRAME  = 2 * SLOT_W * BCK_DIV;
    localparam int FCNT_W = $clog2(FRAME);
    localparam int HALF   = BCK_DIV / 2;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FRAME - 1);

    logic [FCNT_W-1:0]   fcnt;
    logic [FCNT_W-1:0]   fcnt_next;
    logic                mode;
    int                  cur_ph;
    int                  cur_bit;
    int                  cur_slot;
    int                  nxt_ph;
    int                  nxt_slot;
    int                  first_bit;
    int                  last_bit;
    logic                sample_en;
    logic                last_cap;
    logic [SAMPLE_W-1:0] shift;
    logic [SAMPLE_W-1:0] shifted;
    logic [SAMPLE_W-1:0] left_hold;
    logic [SAMPLE_W-1:0] right_word;
    logic                push_p1;

    logic [SAMPLE_W-1:0] mem_left  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_right [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_next;
    logic [PW-1:0]       rd_next;
    logic                full;
    logic                empty_next;
    logic                pop;
    logic                push_ok;
    logic [SAMPLE_W-1:0] head_left_next;
    logic [SAMPLE_W-1:0] head_right_next;

    assign scki = clk;

    // Next frame position: free-running while enabled, parked at 0 otherwise.
    always_comb begin
        fcnt_next = '0;
        if (en) begin
            fcnt_next = (fcnt == FCNT_MAX) ? '0 : fcnt + FCNT_W'(1);
        end
    end

    // Decode the current and next frame positions into phase, bit and slot.
    always_comb begin
        cur_ph    = int'(fcnt) % BCK_DIV;
        cur_bit   = (int'(fcnt) / BCK_DIV) % SLOT_W;
        cur_slot  = int'(fcnt) / (SLOT_W * BCK_DIV);
        nxt_ph    = int'(fcnt_next) % BCK_DIV;
        nxt_slot  = int'(fcnt_next) / (SLOT_W * BCK_DIV);
        // I2S delays the MSB by one bck; left-justified starts on bit 0.
        first_bit = mode ? 0 : 1;
        last_bit  = first_bit + SAMPLE_W - 1;
        sample_en = en && (cur_ph == HALF) && (cur_bit >= first_bit) && (cur_bit <= last_bit);
        last_cap  = sample_en && (cur_bit == last_bit);
        shifted   = {shift[SAMPLE_W-2:0], din};
    end

    // Frame counter and per-frame format latch.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fcnt <= '0;
            mode <= 1'b0;
        end else begin
            fcnt <= fcnt_next;
            if (en && fcnt == '0) begin
                mode <= fmt;
            end
        end
    end

    // bck/lrck registered from the next position so they line up with fcnt.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bck  <= 1'b0;
            lrck <= 1'b0;
        end else begin
            bck  <= (nxt_ph >= HALF);
            lrck <= (nxt_slot != 0);
        end
    end

    // Serial capture; a pair is requested only when the right word completes,
    // so any frame cut short by en or reset never reaches the FIFO.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift      <= '0;
            left_hold  <= '0;
            right_word <= '0;
            push_p1    <= 1'b0;
        end else begin
            push_p1 <= 1'b0;
            if (sample_en) begin
                shift <= shifted;
                if (last_cap) begin
                    if (cur_slot == 0) begin
                        left_hold <= shifted;
                    end else begin
                        right_word <= shifted;
                        push_p1    <= 1'b1;
                    end
                end
            end
        end
    end

    // FIFO control: next pointers and the entry that will be at the head.
    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = out_valid && out_ready;
        push_ok    = push_p1 && (!full || pop);
        wr_next    = wr_ptr + {{(PW-1){1'b0}}, push_ok};
        rd_next    = rd_ptr + {{(PW-1){1'b0}}, pop};
        empty_next = (wr_next == rd_next);
        if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
            head_left_next  = left_hold;
            head_right_next = right_word;
        end else begin
            head_left_next  = mem_left[rd_next[AW-1:0]];
            head_right_next = mem_right[rd_next[AW-1:0]];
        end
    end

    // FIFO storage; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_left[wr_ptr[AW-1:0]]  <= left_hold;
            mem_right[wr_ptr[AW-1:0]] <= right_word;
        end
    end

    // FIFO pointers, registered head outputs and sticky overflow.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            out_valid <= !empty_next;
            if (!empty_next) begin
                out_left  <= head_left_next;
                out_right <= head_right_next;
            end
            if (push_p1 && full && !pop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SAMPLE_W, default 24: captured sample width in bits; legal range 8..SLOT_W.
REQ-002 Parameter SLOT_W, default 32: bck periods per channel slot; legal values 16, 24, 32.
REQ-003 Parameter BCK_DIV, default 4: clk cycles per bck period; even, legal range 2..16.
REQ-004 Parameter FIFO_DEPTH, default 4: sample-pair FIFO entries; power of two, legal range 2..16.
REQ-005 clk  in  1  system clock, also forwarded as ADC system clock; one clock; all registers on posedge clk.
REQ-006 nreset  in  1  reset, asynchronous assert, active-low.
REQ-007 en  in  1  enables bck/lrck generation and capture.
REQ-008 fmt  in  1  0 = I2S (one-bck MSB delay), 1 = left-justified; sampled only at frame start.
REQ-009 din  in  1  serial data from ADC.
REQ-010 bck  out  1  bit clock.
REQ-011 lrck  out  1  channel clock: 0 = left slot, 1 = right slot.
REQ-012 scki  out  1  equals clk.
REQ-013 out_left  out  SAMPLE_W  FIFO head, left sample.
REQ-014 out_right  out  SAMPLE_W  FIFO head, right sample.
REQ-015 out_valid  out  1  FIFO non-empty.
REQ-016 out_ready  in  1  consumer accepts head when out_valid.
REQ-017 overflow  out  1  sticky: a pair was dropped.
REQ-018 clear_ovf  in  1  synchronous clear of overflow.

Function
REQ-019 Frame counter fcnt counts 0..2*SLOT_W*BCK_DIV-1 on clk while en=1, wraps to 0; held at 0 while en=0.
REQ-020 Decode: ph = fcnt mod BCK_DIV; bit b = (fcnt/BCK_DIV) mod SLOT_W; slot = fcnt/(SLOT_W*BCK_DIV).
REQ-021 bck = 1 iff ph >= BCK_DIV/2; lrck = slot; both driven from registers, 0 while en=0.
REQ-022 No register is clocked by bck; din is sampled in the clk domain on the cycle with ph == BCK_DIV/2, the first cycle bck is high.
REQ-023 Captured bits: I2S, b = 1..SAMPLE_W; left-justified, b = 0..SAMPLE_W-1; MSB first; remaining bits ignored.
REQ-024 fmt is latched into an active-mode register when fcnt == 0; a change mid-frame takes effect from the next frame.
REQ-025 The completed left word moves to a holding register at its last captured bit; the right word completes at its last captured bit.
REQ-026 Push {left hold, right word} into FIFO exactly one clk after the right channel's last captured bit: one push per frame.
REQ-027 First frame after reset or en rising: left slot capture starts at fcnt 0; no partial pair ever pushed.
REQ-028 en falling mid-frame: partial capture discarded; FIFO contents and overflow retained.
REQ-029 Pop occurs on a cycle with out_valid & out_ready; out_left/out_right show the head entry, registered, stable while out_valid & !out_ready.
REQ-030 Push while full with no simultaneous pop: pair dropped, FIFO unchanged, overflow <= 1.
REQ-031 Push while full with simultaneous pop: both occur, no overflow.
REQ-032 Push while empty: out_valid rises the following cycle; no same-cycle bypass.
REQ-033 overflow clears on clear_ovf; a drop in the same cycle as clear_ovf wins (overflow = 1).
REQ-034 Occupancy pointers use log2(FIFO_DEPTH)+1 bits; full and empty derive from them; wrap-around is seamless.

Reset
REQ-035 nreset low asynchronously sets fcnt, shift, holding and mode registers, and FIFO pointers to 0; bck=0, lrck=0, out_valid=0, out_left=0, out_right=0, overflow=0.
REQ-036 Reset mid-frame or with a non-empty FIFO discards all data; generation restarts at fcnt 0 on the first clk after deassertion with en=1.

Verification (defaults: SAMPLE_W=24, SLOT_W=32, BCK_DIV=4, 256 clk per frame)
REQ-037 I2S, ADC model left=0xA5C3F1, right=0x123456, out_ready=1 -> one pair per 256 clk with exactly these values; bck period 4 clk; lrck period 256 clk.
REQ-038 fmt=1, left-justified model left=0x800001, right=0x7FFFFF -> pair 0x800001/0x7FFFFF; fmt toggled at fcnt=100 -> old mode completes that frame.
REQ-039 out_ready=0 for 6 frames -> 4 pairs held in order, overflow=1 after frame 5; clear_ovf pulse -> overflow=0; drain yields the first 4 pairs.
REQ-040 FIFO full, out_ready=1 on the push cycle -> no overflow; order is preserved across pointer wrap over 20 frames.
REQ-041 nreset pulse at fcnt=150 with 2 entries queued -> out_valid=0 immediately; the first new pair is pushed one clk after the right slot's last captured bit.
REQ-042 en low at fcnt=60 for 300 clk -> bck=lrck=0, no push, no partial pair; capture resumes cleanly on the next frame.
